// File: rtl/hex_digit_counter_pkg.sv
// rtl/hex_digit_counter_pkg.sv - digit geometry, key indices and the per-digit step function
package hex_digit_counter_pkg;

  localparam int NDIG  = 4;
  localparam int DIG_W = 4;

  localparam logic [DIG_W-1:0] BCD_MAX = 4'h9;
  localparam logic [DIG_W-1:0] HEX_MAX = 4'hF;

  localparam int KEY_RUN = 0;
  localparam int KEY_CLR = 1;

  // Returns {carry/borrow out, next digit}; digits above 9 left over from hex
  // mode count as "at maximum" going up and reload 9 without borrow going down.
  function automatic logic [DIG_W:0] digit_next(input logic [DIG_W-1:0] d,
                                                input logic             cin,
                                                input logic             bcd,
                                                input logic             up);
    logic [DIG_W-1:0] mx;
    mx = bcd ? BCD_MAX : HEX_MAX;
    digit_next = {1'b0, d};
    if (cin) begin
      if (up) begin
        if (d >= mx) digit_next = {1'b1, {DIG_W{1'b0}}};
        else         digit_next = {1'b0, d + DIG_W'(1)};
      end else begin
        if (bcd && (d > BCD_MAX)) digit_next = {1'b0, BCD_MAX};
        else if (d == '0)         digit_next = {1'b1, mx};
        else                      digit_next = {1'b0, d - DIG_W'(1)};
      end
    end
  endfunction

endpackage

// File: rtl/hex_digit_counter_key_debounce.sv
// rtl/hex_digit_counter_key_debounce.sv - synchronizer, debouncer and press detector for one active-low key
module key_debounce
  #(parameter int DEB_CYCLES = 500_000)
  (input  logic CLOCK_50,
   input  logic RST,
   input  logic key_n,
   output logic press);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync;
  logic          level;
  logic [CW-1:0] cnt;

  // The press pulse is registered together with the debounced level falling.
  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], key_n};
      press <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          level <= sync[1];
          cnt   <= '0;
          press <= ~sync[1];
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/hex_digit_counter.sv
// rtl/hex_digit_counter.sv - four-digit hex/BCD up/down counter with run/pause and clear keys
module hex_digit_counter
  import hex_digit_counter_pkg::*;
  #(parameter int TICK_DIV   = 50_000_000,
    parameter int DEB_CYCLES = 500_000)
  (input  logic        CLOCK_50,
   input  logic        RST,
   input  logic [1:0]  KEY,
   input  logic        BCD,
   input  logic        UP,
   output logic [15:0] DIGITS,
   output logic        RUNNING,
   output logic        WRAP);

  localparam int PW = $clog2(TICK_DIV);

  logic                  run_press;
  logic                  clr_press;
  logic [PW-1:0]         presc;
  logic [NDIG:0]         carry;
  logic [NDIG*DIG_W-1:0] nxt_all;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_run
    (.CLOCK_50(CLOCK_50), .RST(RST), .key_n(KEY[KEY_RUN]), .press(run_press));

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key_clr
    (.CLOCK_50(CLOCK_50), .RST(RST), .key_n(KEY[KEY_CLR]), .press(clr_press));

  // Digit 0 always sees a carry-in; the chain is only committed on a step.
  assign carry[0] = 1'b1;

  generate
    for (genvar i = 0; i < NDIG; i++) begin : g_dig
      logic [DIG_W:0] res;
      assign res                        = digit_next(DIGITS[i*DIG_W +: DIG_W], carry[i], BCD, UP);
      assign carry[i+1]                 = res[DIG_W];
      assign nxt_all[i*DIG_W +: DIG_W]  = res[DIG_W-1:0];
    end
  endgenerate

  always_ff @(posedge CLOCK_50 or posedge RST) begin
    if (RST) begin
      presc   <= '0;
      DIGITS  <= '0;
      RUNNING <= 1'b0;
      WRAP    <= 1'b0;
    end else begin
      WRAP <= 1'b0;
      if (run_press) RUNNING <= ~RUNNING;
      // Clear overrides a coincident step and leaves RUNNING to the toggle key.
      if (clr_press) begin
        presc  <= '0;
        DIGITS <= '0;
      end else if (RUNNING) begin
        if (presc == PW'(TICK_DIV - 1)) begin
          presc  <= '0;
          DIGITS <= nxt_all;
          WRAP   <= carry[NDIG];
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_hex_digit_counter.sv
// tb/tb_hex_digit_counter.sv - scoreboard bench for hex_digit_counter
module tb_hex_digit_counter;

  localparam int TICK_DIV   = 4;
  localparam int DEB_CYCLES = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  key = 2'b11;
  logic        bcd = 1'b0;
  logic        up  = 1'b0;
  logic [15:0] digits;
  logic        running;
  logic        wrap;

  hex_digit_counter #(.TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB_CYCLES)) dut
    (.CLOCK_50(clk), .RST(rst), .KEY(key), .BCD(bcd), .UP(up),
     .DIGITS(digits), .RUNNING(running), .WRAP(wrap));

  always #5 clk = ~clk;

  int cyc = 0;
  int last_cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  logic exp_running = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [15:0] d;
    logic        w;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Waits (bounded) for DIGITS to change, then pops and compares the oldest expectation.
  task automatic wait_step(input string tag);
    logic [15:0] prev;
    exp_t        e;
    int          n;
    prev = digits;
    n    = 0;
    while (digits == prev && n < 40) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    check({tag, "_digits"}, 32'(digits), 32'(e.d));
    check({tag, "_wrap"}, 32'(wrap), 32'(e.w));
    check({tag, "_gap"}, cyc - last_cyc, TICK_DIV);
    check({tag, "_running"}, 32'(running), 32'(exp_running));
    last_cyc = cyc;
    if (e.w) begin
      @(negedge clk);
      check({tag, "_wrap_len"}, 32'(wrap), 32'd0);
    end
  endtask

  task automatic expect_step(input string tag, input logic [15:0] d, input logic w);
    sb.push_back('{d: d, w: w});
    wait_step(tag);
  endtask

  // Key goes low two cycles after the last step, so its press event meets the
  // second following step: that step is replaced by the clear.
  task automatic clear_on_step(input string tag, input logic [15:0] step_val);
    while (cyc < last_cyc + 2) @(negedge clk);
    key[1] = 1'b0;
    expect_step({tag, "_pre"}, step_val, 1'b0);
    expect_step({tag, "_clr"}, 16'h0000, 1'b0);
    key[1] = 1'b1;
  endtask

  initial begin
    int c0;
    int n;

    #13 rst = 1'b1;
    #1;
    check("rst_digits", 32'(digits), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (50) begin
      @(negedge clk);
      check("idle_digits", 32'(digits), 32'd0);
      check("idle_running", 32'(running), 32'd0);
      check("idle_wrap", 32'(wrap), 32'd0);
    end

    @(posedge clk); #1 key[0] = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 key[0] = 1'b1;
    @(posedge clk); #1 key[0] = 1'b0;
    c0 = cyc;
    n  = 0;
    while (!running && n < 20) begin
      @(negedge clk);
      n++;
    end
    exp_running = 1'b1;
    check("deb_latency", cyc - c0, 6);
    last_cyc = cyc;
    key[0]   = 1'b1;

    expect_step("hex_dn0", 16'hFFFF, 1'b1);
    expect_step("hex_dn1", 16'hFFFE, 1'b0);
    up = 1'b1;
    expect_step("hex_up0", 16'hFFFF, 1'b0);
    expect_step("hex_up1", 16'h0000, 1'b1);

    bcd = 1'b1;
    for (int i = 1; i <= 100; i++) expect_step("bcd_up", to_bcd(i), 1'b0);
    up = 1'b0;
    expect_step("bcd_dn0", 16'h0099, 1'b0);
    expect_step("bcd_dn1", 16'h0098, 1'b0);
    clear_on_step("clr_bcd", 16'h0097);
    expect_step("bcd_wrap", 16'h9999, 1'b1);

    bcd = 1'b0;
    up  = 1'b1;
    clear_on_step("clr_hex", 16'h999A);
    for (int i = 1; i <= 12; i++) expect_step("hex_c", 16'(i), 1'b0);
    bcd = 1'b1;
    expect_step("residue", 16'h0010, 1'b0);

    clear_on_step("clr_a", 16'h0011);
    for (int i = 1; i <= 4; i++) expect_step("pre_col", 16'(i), 1'b0);
    clear_on_step("collide", 16'h0005);
    expect_step("post_col", 16'h0001, 1'b0);

    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_digits", 32'(digits), 32'd0);
    check("midrst_running", 32'(running), 32'd0);
    check("midrst_wrap", 32'(wrap), 32'd0);
    #20 rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
